i2c_target_responder: RTL and testbench
=======================================

Name: i2c_target_responder

Overview:
- Single-address I2C target (slave) on the same two-wire bus as the team's I2C controller; consumes the SCL/SDA traffic that controller produces.
- Decodes START/STOP, matches a fixed 7-bit address, ACKs, delivers received write bytes to the fabric, and serves read bytes from the fabric.
- Used as the bus-side model and loopback partner for controller bring-up. It is also the synthesizable target for on-chip peripherals.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this block ACKs.
- SYNC_STAGES, 2, flops in each SCL/SDA input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- scl  input  1  bus clock from controller, asynchronous to clk
- sda  inout  1  open-drain data; block drives 1'b0 or 1'bz only, never 1
- tx_data  input  8  byte to return on a read; sampled when tx_req pulses
- tx_req  output  1  1-cycle pulse: tx_data captured for the next read byte
- rx_data  output  8  last byte received in a write transfer
- rx_valid  output  1  1-cycle pulse: rx_data updated
- busy  output  1  high from address match until STOP or IDLE
- addr_nack  output  1  sticky flag: last address phase did not match; cleared on next START

Behaviour:
- Reset: clk is the clock; rst is asynchronous and active-high. Reset is async and may arrive mid-operation. All outputs go to 0: sda is released (z), rx_data=8'h00, tx_req=0, rx_valid=0, busy=0, addr_nack=0. State returns to IDLE and synchronizers preset to 1.
- Input path: scl and sda pass through SYNC_STAGES flops, then one edge-detect register. Every bus action occurs SYNC_STAGES+1 clk after the pin transition. The bench must allow this.
- Events, all on synchronized signals:
  - START = sda 1->0 while scl=1.
  - STOP = sda 0->1 while scl=1.
  - Bit sample = scl rising edge.
  - Drive change = scl falling edge.
- START in any state, including repeated START: go to ADDR, bit counter=7, release sda, clear addr_nack.
- STOP in any state: go to IDLE, release sda, busy=0. No rx_valid for a partial byte.
- START/STOP detection takes priority over the bit sample in the same cycle.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first on scl rise into {addr[6:0], rw}. On the falling edge after bit 0:
    - match: ACK_ADDR, drive sda low, busy=1.
    - mismatch: set addr_nack and go to WAIT_STOP with sda released.
  - ACK_ADDR: hold sda low through one scl high. On the next scl fall:
    - rw=0: release sda, go to RX_DATA.
    - rw=1: pulse tx_req, load tx_data into the shift register, drive bit7 (0=drive low, 1=release), go to TX_DATA.
  - RX_DATA: sample 8 bits on scl rise. On the falling edge after bit 0:
    - rx_data<=byte and pulse rx_valid in that same cycle.
    - Drive ACK low and go to RX_ACK.
  - RX_ACK: release sda on the next scl fall, return to RX_DATA. Writes may be multi-byte without limit.
  - TX_DATA: shift on each scl fall. On the fall after bit 0, release sda and go to TX_ACK.
  - TX_ACK: sample the controller's ACK on scl rise.
    - sda=0 (ACK): on the next fall pulse tx_req, load the next byte, drive its bit7, go to TX_DATA.
    - sda=1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda released; ignore bits until START or STOP.
- Bit counter is 3 bits and counts 7 down to 0. Wrap from 0 occurs only via the ACK states.
- sda is driven only in ACK_ADDR, RX_ACK, and TX_DATA (zero bits). The block never drives high.
- rx_valid and tx_req are never high in the same cycle. Each is at most one pulse per byte.

Test Plan:
- Write addr 0x50 rw=0, data 0xA5, then STOP:
  - sda low during both 9th clocks.
  - rx_data=0xA5 with exactly one rx_valid pulse.
  - busy falls 3 clk after STOP.
- Write addr 0x51:
  - sda stays z for the 9th clock; addr_nack=1.
  - Following data byte 0xFF produces no rx_valid.
  - STOP then returns to IDLE.
- Read addr 0x50 rw=1, tx_data=0x3C, controller NACKs:
  - Bits seen on scl rise are 0,0,1,1,1,1,0,0.
  - One tx_req pulse; sda released after bit 0.
  - WAIT_STOP, then STOP goes to IDLE.
- Read two bytes (0x81 then 0x7E) with controller ACK on the first:
  - Two tx_req pulses.
  - Second byte starts on the scl fall after the ACK.
- Write 0x12, repeated START, then read 0x50:
  - rx_valid for 0x12.
  - addr_nack cleared; read proceeds correctly.
- Assert rst while driving ACK low:
  - sda goes z immediately (async), all outputs 0.
  - After release, the next START is decoded normally.
- STOP after 4 data bits of a write:
  - Immediate IDLE, no rx_valid, rx_data unchanged.

Source files
------------

// File: rtl/i2c_target_responder.sv
// Single-address I2C target: decodes START/STOP, ACKs TARGET_ADDR, hands write
// bytes to the fabric on rx_data and serves read bytes from tx_data via open-drain sda.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       addr_nack
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  shift_q;
    logic        done_q;
    logic        rw_q;
    logic        sdaLow_q;
    logic [7:0]  rxData_q;
    logic        rxValid_q;
    logic        txReq_q;
    logic        busy_q;
    logic        addrNack_q;

    logic sclS, sdaS, sclRise, sclFall, startDet, stopDet;

    // Synchronizers preset to 1 so reset looks like an idle bus and fakes no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda};
            sclPrev_q <= sclS;
            sdaPrev_q <= sdaS;
        end
    end

    assign sclS     = sclSync_q[SYNC_STAGES-1];
    assign sdaS     = sdaSync_q[SYNC_STAGES-1];
    assign sclRise  = sclS & ~sclPrev_q;
    assign sclFall  = ~sclS & sclPrev_q;
    assign startDet = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    assign stopDet  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd7;
            shift_q    <= 8'h00;
            done_q     <= 1'b0;
            rw_q       <= 1'b0;
            sdaLow_q   <= 1'b0;
            rxData_q   <= 8'h00;
            rxValid_q  <= 1'b0;
            txReq_q    <= 1'b0;
            busy_q     <= 1'b0;
            addrNack_q <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            txReq_q   <= 1'b0;
            if (startDet) begin
                state_q    <= ADDR;
                cnt_q      <= 3'd7;
                done_q     <= 1'b0;
                sdaLow_q   <= 1'b0;
                addrNack_q <= 1'b0;
            end else if (stopDet) begin
                state_q  <= IDLE;
                done_q   <= 1'b0;
                sdaLow_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    // done_q marks that bit 0 was sampled; the byte is acted on at the following fall.
                    ADDR, RX_DATA: begin
                        if (sclRise) begin
                            shift_q <= {shift_q[6:0], sdaS};
                            if (cnt_q == 3'd0) done_q <= 1'b1;
                            else               cnt_q  <= cnt_q - 3'd1;
                        end else if (sclFall && done_q) begin
                            done_q <= 1'b0;
                            cnt_q  <= 3'd7;
                            if (state_q == RX_DATA) begin
                                rxData_q  <= shift_q;
                                rxValid_q <= 1'b1;
                                sdaLow_q  <= 1'b1;
                                state_q   <= RX_ACK;
                            end else if (shift_q[7:1] == TARGET_ADDR) begin
                                rw_q     <= shift_q[0];
                                sdaLow_q <= 1'b1;
                                busy_q   <= 1'b1;
                                state_q  <= ACK_ADDR;
                            end else begin
                                addrNack_q <= 1'b1;
                                state_q    <= WAIT_STOP;
                            end
                        end
                    end
                    ACK_ADDR: begin
                        if (sclFall) begin
                            if (rw_q) begin
                                txReq_q  <= 1'b1;
                                shift_q  <= tx_data;
                                sdaLow_q <= ~tx_data[7];
                                cnt_q    <= 3'd7;
                                state_q  <= TX_DATA;
                            end else begin
                                sdaLow_q <= 1'b0;
                                state_q  <= RX_DATA;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (sclFall) begin
                            sdaLow_q <= 1'b0;
                            state_q  <= RX_DATA;
                        end
                    end
                    // Bits are counted on rises; each fall presents the next bit until bit 0 has gone out.
                    TX_DATA: begin
                        if (sclRise) begin
                            if (cnt_q == 3'd0) done_q <= 1'b1;
                            else               cnt_q  <= cnt_q - 3'd1;
                        end else if (sclFall) begin
                            if (done_q) begin
                                done_q   <= 1'b0;
                                sdaLow_q <= 1'b0;
                                state_q  <= TX_ACK;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sdaLow_q <= ~shift_q[6];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (sclRise) begin
                            if (sdaS) state_q <= WAIT_STOP;
                            else      done_q  <= 1'b1;
                        end else if (sclFall && done_q) begin
                            done_q   <= 1'b0;
                            txReq_q  <= 1'b1;
                            shift_q  <= tx_data;
                            sdaLow_q <= ~tx_data[7];
                            cnt_q    <= 3'd7;
                            state_q  <= TX_DATA;
                        end
                    end
                    default: begin
                        sdaLow_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda       = sdaLow_q ? 1'b0 : 1'bz;
    assign rx_data   = rxData_q;
    assign rx_valid  = rxValid_q;
    assign tx_req    = txReq_q;
    assign busy      = busy_q;
    assign addr_nack = addrNack_q;
endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-level I2C controller model drives directed
// and random transfers; expected bus/fabric behaviour comes from transaction-level rules.
module tb_i2c_target_responder;
    localparam logic [6:0] TARGET = 7'h50;
    localparam int         Q      = 8;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       scl     = 1'b1;
    logic       sdaLow  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req, rx_valid, busy, addr_nack;
    logic [7:0] rx_data;
    wire        sdaBus;

    int         checkCount = 0;
    int         passCount  = 0;
    int         rxPulses   = 0;
    int         txPulses   = 0;
    logic [7:0] lastRx     = 8'h00;
    logic       overlap    = 1'b0;

    assign sdaBus = sdaLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    always #5 clk = ~clk;

    i2c_target_responder #(.TARGET_ADDR(TARGET), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sdaBus), .tx_data(tx_data),
        .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .addr_nack(addr_nack)
    );

    // Pulse monitor: counts fabric-side handshakes so tests can compare deltas.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxPulses++;
            lastRx = rx_data;
        end
        if (tx_req) txPulses++;
        if (rx_valid && tx_req) overlap = 1'b1;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busStart();
        if (!scl) begin
            sdaLow = 1'b0; waitClk(Q);
            scl = 1'b1;    waitClk(Q);
        end
        sdaLow = 1'b1; waitClk(Q);
        scl = 1'b0;    waitClk(Q);
    endtask

    task automatic busStop();
        sdaLow = 1'b1; waitClk(Q);
        scl = 1'b1;    waitClk(Q);
        sdaLow = 1'b0; waitClk(Q);
    endtask

    task automatic clockBit(input logic b, output logic seen);
        sdaLow = ~b;  waitClk(Q);
        scl = 1'b1;   waitClk(Q);
        seen = sdaBus; waitClk(Q);
        scl = 1'b0;   waitClk(Q);
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        logic seen;
        for (int i = 7; i >= 0; i--) clockBit(b[i], seen);
        clockBit(1'b1, ack);
    endtask

    task automatic readByte(input logic ackBit, input logic [7:0] nextTx,
                            output logic [7:0] v, output logic ackSeen);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            clockBit(1'b1, seen);
            v[i] = seen;
        end
        tx_data = nextTx;
        clockBit(ackBit, ackSeen);
    endtask

    task automatic test_reset();
        waitClk(3);
        checkCount++; if (sdaBus !== 1'b1)   $display("[TB] FAIL reset_sda: got %b want 1", sdaBus);      else passCount++;
        checkCount++; if (busy !== 1'b0)     $display("[TB] FAIL reset_busy: got %b want 0", busy);       else passCount++;
        checkCount++; if (rx_data !== 8'h00) $display("[TB] FAIL reset_rxdata: got %h want 00", rx_data); else passCount++;
        checkCount++; if ({rx_valid, tx_req, addr_nack} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b want 000", {rx_valid, tx_req, addr_nack}); else passCount++;
        rst = 1'b0;
        waitClk(Q);
    endtask

    task automatic test_write_basic();
        logic ack;
        int   rx0 = rxPulses;
        busStart();
        sendByte({TARGET, 1'b0}, ack);
        checkCount++; if (ack !== 1'b0) $display("[TB] FAIL wr_addr_ack: got %b want 0", ack); else passCount++;
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL wr_busy: got %b want 1", busy); else passCount++;
        sendByte(8'hA5, ack);
        checkCount++; if (ack !== 1'b0) $display("[TB] FAIL wr_data_ack: got %b want 0", ack); else passCount++;
        checkCount++; if (rxPulses - rx0 !== 1) $display("[TB] FAIL wr_rxvalid_count: got %0d want 1", rxPulses - rx0); else passCount++;
        checkCount++; if (rx_data !== 8'hA5) $display("[TB] FAIL wr_rxdata: got %h want a5", rx_data); else passCount++;
        sdaLow = 1'b1; waitClk(Q);
        scl = 1'b1;    waitClk(Q);
        sdaLow = 1'b0; waitClk(2);
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL wr_busy_before_stop: got %b want 1", busy); else passCount++;
        waitClk(1);
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL wr_busy_after_stop: got %b want 0", busy); else passCount++;
        waitClk(Q);
    endtask

    task automatic test_addr_nack();
        logic ack;
        int   rx0 = rxPulses;
        busStart();
        sendByte({7'h51, 1'b0}, ack);
        checkCount++; if (ack !== 1'b1) $display("[TB] FAIL nack_addr_sda: got %b want 1", ack); else passCount++;
        checkCount++; if (addr_nack !== 1'b1) $display("[TB] FAIL nack_flag: got %b want 1", addr_nack); else passCount++;
        sendByte(8'hFF, ack);
        checkCount++; if (ack !== 1'b1) $display("[TB] FAIL nack_data_sda: got %b want 1", ack); else passCount++;
        checkCount++; if (rxPulses !== rx0) $display("[TB] FAIL nack_no_rxvalid: got %0d want %0d", rxPulses, rx0); else passCount++;
        busStop();
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL nack_busy: got %b want 0", busy); else passCount++;
    endtask

    task automatic test_read_nack();
        logic       ack, ackSeen;
        logic [7:0] v;
        int         tx0 = txPulses;
        tx_data = 8'h3C;
        busStart();
        checkCount++; if (addr_nack !== 1'b0) $display("[TB] FAIL rd_nack_cleared: got %b want 0", addr_nack); else passCount++;
        sendByte({TARGET, 1'b1}, ack);
        checkCount++; if (ack !== 1'b0) $display("[TB] FAIL rd_addr_ack: got %b want 0", ack); else passCount++;
        readByte(1'b1, 8'h00, v, ackSeen);
        checkCount++; if (v !== 8'h3C) $display("[TB] FAIL rd_bits: got %h want 3c", v); else passCount++;
        checkCount++; if (ackSeen !== 1'b1) $display("[TB] FAIL rd_release_after_bit0: got %b want 1", ackSeen); else passCount++;
        checkCount++; if (txPulses - tx0 !== 1) $display("[TB] FAIL rd_txreq_count: got %0d want 1", txPulses - tx0); else passCount++;
        readByte(1'b1, 8'h00, v, ackSeen);
        checkCount++; if (v !== 8'hFF) $display("[TB] FAIL rd_wait_stop_idle_bus: got %h want ff", v); else passCount++;
        busStop();
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rd_busy_after_stop: got %b want 0", busy); else passCount++;
    endtask

    task automatic test_read_two();
        logic       ack, ackSeen;
        logic [7:0] v;
        int         tx0 = txPulses;
        tx_data = 8'h81;
        busStart();
        sendByte({TARGET, 1'b1}, ack);
        readByte(1'b0, 8'h7E, v, ackSeen);
        checkCount++; if (v !== 8'h81) $display("[TB] FAIL rd2_first: got %h want 81", v); else passCount++;
        readByte(1'b1, 8'h00, v, ackSeen);
        checkCount++; if (v !== 8'h7E) $display("[TB] FAIL rd2_second: got %h want 7e", v); else passCount++;
        checkCount++; if (txPulses - tx0 !== 2) $display("[TB] FAIL rd2_txreq_count: got %0d want 2", txPulses - tx0); else passCount++;
        busStop();
    endtask

    task automatic test_repeated_start();
        logic       ack, ackSeen;
        logic [7:0] v;
        logic [7:0] txByte = 8'($urandom);
        busStart();
        sendByte({TARGET, 1'b0}, ack);
        sendByte(8'h12, ack);
        checkCount++; if (lastRx !== 8'h12) $display("[TB] FAIL rs_write_byte: got %h want 12", lastRx); else passCount++;
        tx_data = txByte;
        busStart();
        checkCount++; if (addr_nack !== 1'b0) $display("[TB] FAIL rs_addr_nack: got %b want 0", addr_nack); else passCount++;
        sendByte({TARGET, 1'b1}, ack);
        checkCount++; if (ack !== 1'b0) $display("[TB] FAIL rs_read_ack: got %b want 0", ack); else passCount++;
        readByte(1'b1, 8'h00, v, ackSeen);
        checkCount++; if (v !== txByte) $display("[TB] FAIL rs_read_byte: got %h want %h", v, txByte); else passCount++;
        busStop();
    endtask

    task automatic test_reset_mid_ack();
        logic       seen, ack;
        logic [7:0] addrByte = {TARGET, 1'b0};
        logic [7:0] dataByte = 8'($urandom_range(1, 255));
        busStart();
        for (int i = 7; i >= 0; i--) clockBit(addrByte[i], seen);
        sdaLow = 1'b0; waitClk(Q);
        scl = 1'b1;    waitClk(Q);
        checkCount++; if (sdaBus !== 1'b0) $display("[TB] FAIL rstack_driven: got %b want 0", sdaBus); else passCount++;
        #2 rst = 1'b1;
        #1;
        checkCount++; if (sdaBus !== 1'b1) $display("[TB] FAIL rstack_sda_release: got %b want 1", sdaBus); else passCount++;
        checkCount++; if ({busy, rx_valid, tx_req, addr_nack} !== 4'b0000)
            $display("[TB] FAIL rstack_flags: got %b want 0000", {busy, rx_valid, tx_req, addr_nack}); else passCount++;
        checkCount++; if (rx_data !== 8'h00) $display("[TB] FAIL rstack_rxdata: got %h want 00", rx_data); else passCount++;
        waitClk(3);
        rst = 1'b0;
        scl = 1'b0; waitClk(Q);
        scl = 1'b1; waitClk(Q);
        busStart();
        sendByte({TARGET, 1'b0}, ack);
        checkCount++; if (ack !== 1'b0) $display("[TB] FAIL rstack_after_ack: got %b want 0", ack); else passCount++;
        sendByte(dataByte, ack);
        checkCount++; if (rx_data !== dataByte) $display("[TB] FAIL rstack_after_data: got %h want %h", rx_data, dataByte); else passCount++;
        busStop();
    endtask

    task automatic test_partial_stop();
        logic       ack, seen;
        logic [7:0] prevRx = rx_data;
        int         rx0 = rxPulses;
        busStart();
        sendByte({TARGET, 1'b0}, ack);
        for (int i = 0; i < 4; i++) clockBit(1'($urandom), seen);
        busStop();
        checkCount++; if (rxPulses !== rx0) $display("[TB] FAIL partial_rxvalid: got %0d want %0d", rxPulses, rx0); else passCount++;
        checkCount++; if (rx_data !== prevRx) $display("[TB] FAIL partial_rxdata: got %h want %h", rx_data, prevRx); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL partial_busy: got %b want 0", busy); else passCount++;
    endtask

    // Reference: a matching address is ACKed and every byte moves; otherwise the bus stays released.
    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic       match = ($urandom_range(0, 2) != 0);
            logic       rw    = 1'($urandom);
            logic [6:0] addr  = match ? TARGET : 7'($urandom);
            int         n     = $urandom_range(1, 3);
            logic [7:0] bytes [3];
            logic       ack, ackSeen;
            logic [7:0] v;
            int         rx0 = rxPulses;
            int         tx0 = txPulses;
            if (!match && addr == TARGET) addr = TARGET ^ 7'h01;
            for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
            busStart();
            sendByte({addr, rw}, ack);
            checkCount++; if (ack !== !match) $display("[TB] FAIL rnd_addr_ack t%0d: got %b want %b", t, ack, !match); else passCount++;
            checkCount++; if (addr_nack !== !match) $display("[TB] FAIL rnd_addr_nack t%0d: got %b want %b", t, addr_nack, !match); else passCount++;
            if (rw) begin
                tx_data = bytes[0];
                for (int i = 0; i < n; i++) begin
                    readByte(i == n - 1, (i < 2) ? bytes[i+1] : 8'h00, v, ackSeen);
                    checkCount++; if (v !== (match ? bytes[i] : 8'hFF))
                        $display("[TB] FAIL rnd_read t%0d b%0d: got %h want %h", t, i, v, match ? bytes[i] : 8'hFF); else passCount++;
                end
                checkCount++; if (txPulses - tx0 !== (match ? n : 0))
                    $display("[TB] FAIL rnd_txreq t%0d: got %0d want %0d", t, txPulses - tx0, match ? n : 0); else passCount++;
            end else begin
                for (int i = 0; i < n; i++) sendByte(bytes[i], ack);
                checkCount++; if (rxPulses - rx0 !== (match ? n : 0))
                    $display("[TB] FAIL rnd_rxvalid t%0d: got %0d want %0d", t, rxPulses - rx0, match ? n : 0); else passCount++;
                if (match) begin
                    checkCount++; if (lastRx !== bytes[n-1])
                        $display("[TB] FAIL rnd_rxdata t%0d: got %h want %h", t, lastRx, bytes[n-1]); else passCount++;
                end
            end
            busStop();
            checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rnd_busy t%0d: got %b want 0", t, busy); else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_addr_nack();
        test_read_nack();
        test_read_two();
        test_repeated_start();
        test_reset_mid_ack();
        test_partial_stop();
        test_random();
        checkCount++; if (overlap !== 1'b0) $display("[TB] FAIL pulse_overlap: got %b want 0", overlap); else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
